// File: rtl/apu_trigger_sequencer_pkg.sv
// Shared constants for the APU trigger sequencer: voice codes, FSM states,
// VGA timing constants and a voice-to-trigger decode helper.
package apu_trigger_sequencer_pkg;

    localparam int unsigned VOICE_W   = 2;
    localparam int unsigned TRIG_W    = 3;
    localparam int unsigned XY_W      = 10;
    localparam int unsigned V_VISIBLE = 480;

    localparam logic [VOICE_W-1:0] VOICE_SAW    = 2'd0;
    localparam logic [VOICE_W-1:0] VOICE_SQUARE = 2'd1;
    localparam logic [VOICE_W-1:0] VOICE_NOISE  = 2'd2;
    localparam logic [VOICE_W-1:0] VOICE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    // One-hot trigger vector {noise, square, saw} for a voice; reserved maps to none.
    function automatic logic [TRIG_W-1:0] voice_onehot(input logic [VOICE_W-1:0] v);
        logic [TRIG_W-1:0] oh;
        oh = '0;
        case (v)
            VOICE_SAW:    oh = 3'b001;
            VOICE_SQUARE: oh = 3'b010;
            VOICE_NOISE:  oh = 3'b100;
            default:      oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/apu_trigger_sequencer_if.sv
// Sound-effect request channel: valid/ready handshake carrying voice and duration.
interface apu_trigger_sequencer_if
    import apu_trigger_sequencer_pkg::*;
#(
    parameter int unsigned DUR_W = 4
);
    logic               evt_valid;
    logic               evt_ready;
    logic [VOICE_W-1:0] evt_voice;
    logic [DUR_W-1:0]   evt_frames;

    modport master (output evt_valid, output evt_voice, output evt_frames, input evt_ready);
    modport slave  (input evt_valid, input evt_voice, input evt_frames, output evt_ready);
endinterface

// File: rtl/apu_trigger_sequencer_fifo.sv
// Synchronous request FIFO; push and pop may coincide, a push while full is ignored.
module apu_trigger_sequencer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array; contents need no reset since occupancy is tracked by cnt.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/apu_trigger_sequencer.sv
// APU trigger sequencer: queues sound-effect requests and plays each one as a
// level trigger on the saw/square/noise APU inputs for a whole number of video
// frames, aligned to a frame tick decoded from the shared VGA x/y counters.
// Optional build macro APU_SEQ_PREEMPT_EN: a queued noise request cuts a
// playing non-noise voice short at the next frame tick.
module apu_trigger_sequencer
    import apu_trigger_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DUR_W      = 4,
    parameter int unsigned V_TICK     = V_VISIBLE
) (
    input  logic                     clk,
    input  logic                     reset,
    apu_trigger_sequencer_if.slave   evt,
    input  logic [XY_W-1:0]          x,
    input  logic [XY_W-1:0]          y,
    output logic                     saw_trigger,
    output logic                     square_trigger,
    output logic                     noise_trigger,
    output logic                     busy
);

    localparam int unsigned FW    = VOICE_W + DUR_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               fifo_push;
    logic               fifo_pop;
    logic [FW-1:0]      fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   fifo_count_d;

    logic [VOICE_W-1:0] head_voice;
    logic [DUR_W-1:0]   head_frames;
    logic               head_ok;
    logic               preempt_c;

    logic               xy_match;
    logic               match_q;
    logic               tick;

    seq_state_t         state;
    seq_state_t         state_d;
    logic [VOICE_W-1:0] voice_q;
    logic [VOICE_W-1:0] voice_d;
    logic [DUR_W-1:0]   remaining;
    logic [DUR_W-1:0]   remaining_d;
    logic [TRIG_W-1:0]  trig_q;
    logic [TRIG_W-1:0]  trig_d;
    logic               busy_d;

    assign evt.evt_ready = !fifo_full && !reset;
    assign fifo_push     = evt.evt_valid && evt.evt_ready;

    apu_trigger_sequencer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({evt.evt_voice, evt.evt_frames}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_voice  = fifo_rdata[FW-1 -: VOICE_W];
    assign head_frames = fifo_rdata[DUR_W-1:0];
    assign head_ok     = !fifo_empty && (head_voice != VOICE_RSVD) && (head_frames != '0);

`ifdef APU_SEQ_PREEMPT_EN
    assign preempt_c = head_ok && (head_voice == VOICE_NOISE) && (voice_q != VOICE_NOISE);
`else
    assign preempt_c = 1'b0;
`endif

    assign xy_match = (x == '0) && (y == XY_W'(V_TICK));

    // Frame tick: one pulse on the first cycle of a match, so a stalled x cannot retrigger it.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            match_q <= xy_match;
            tick    <= xy_match && !match_q;
        end
    end

    // Next-state, trigger and busy decode for the play sequencer.
    always_comb begin
        state_d     = state;
        voice_d     = voice_q;
        remaining_d = remaining;
        trig_d      = trig_q;
        fifo_pop    = 1'b0;

        case (state)
            ST_IDLE: begin
                trig_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_ok) begin
                        voice_d     = head_voice;
                        remaining_d = head_frames;
                        state_d     = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (tick) begin
                    trig_d  = voice_onehot(voice_q);
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    remaining_d = remaining - DUR_W'(1);
                    if ((remaining == DUR_W'(1)) || preempt_c) begin
                        trig_d  = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                trig_d = '0;
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                trig_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        fifo_count_d = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        busy_d       = (state_d != ST_IDLE) || (fifo_count_d != '0);
    end

    // Sequencer state, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            voice_q   <= VOICE_SAW;
            remaining <= '0;
            trig_q    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            voice_q   <= voice_d;
            remaining <= remaining_d;
            trig_q    <= trig_d;
            busy      <= busy_d;
        end
    end

    assign saw_trigger    = trig_q[0];
    assign square_trigger = trig_q[1];
    assign noise_trigger  = trig_q[2];

endmodule
